// File: rtl/spi_pkg.sv
// Shared definitions for the SPI data path: default widths, buffer FSM encodings
// and the SPI_CR1 bit positions used by spi_core and its front end.
package spi_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } spi_state_t;

    localparam int CR1_LSBFE = 0;
    localparam int CR1_SSOE  = 1;
    localparam int CR1_CPHA  = 2;
    localparam int CR1_CPOL  = 3;
    localparam int CR1_MSTR  = 4;
    localparam int CR1_SPTIE = 5;
    localparam int CR1_SPE   = 6;
    localparam int CR1_SPIE  = 7;

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO. A pop frees a slot before the push in the
// same cycle, so a full FIFO that is read and written at once never overflows.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RX_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        flush,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           head,
    output logic [$clog2(RX_DEPTH):0]   count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(RX_DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;
    assign head     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // storage carries data only, so it is left out of the flush
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_data_buffer.sv
// Front end for spi_core: one-byte TX holding register with launch FSM, RX FIFO
// capture on the finished edge, and the SPTEF/SPIF/overrun status and interrupt.
module spi_data_buffer
    import spi_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RX_DEPTH = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        spe_in,
    input  logic                        spie_in,
    input  logic                        sptie_in,
    input  logic                        bus_wr_in,
    input  logic [DATA_W-1:0]           bus_wdata_in,
    input  logic                        bus_rd_in,
    input  logic                        ovr_clr_in,
    output logic [DATA_W-1:0]           dr_rdata_out,
    output logic                        new_tx_out,
    output logic [DATA_W-1:0]           spi_dr_out,
    input  logic                        finished_in,
    input  logic [DATA_W-1:0]           shift_in,
    output logic                        sptef_out,
    output logic                        spif_out,
    output logic                        ovr_out,
    output logic [$clog2(RX_DEPTH):0]   rx_count_out,
    output logic                        tx_drop_out,
    output logic                        busy_out,
    output logic                        irq_out
);

    spi_state_t        state;
    spi_state_t        state_nxt;
    logic              flush;
    logic              finished_q;
    logic              fin_rise;
    logic              launch;
    logic              capture;
    logic              thr_accept;
    logic [DATA_W-1:0] thr;
    logic              thr_valid;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_overflow;

    // disabling the SPI clears everything except the edge detector
    assign flush    = rst_in | ~spe_in;
    assign fin_rise = finished_in & ~finished_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) finished_q <= 1'b0;
        else        finished_q <= finished_in;
    end

    always_ff @(posedge clk_in) begin
        if (flush) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (thr_valid) state_nxt = ST_BUSY;
            ST_BUSY: if (fin_rise)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        launch  = 1'b0;
        capture = 1'b0;
        case (state)
            ST_IDLE: launch  = thr_valid & spe_in;
            ST_BUSY: capture = fin_rise & spe_in;
            default: ;
        endcase
    end

    // a launch empties thr in the same cycle, so a coincident write still lands
    assign thr_accept = bus_wr_in & (~thr_valid | launch);

    always_ff @(posedge clk_in) begin
        if (flush) begin
            thr_valid   <= 1'b0;
            new_tx_out  <= 1'b0;
            spi_dr_out  <= '0;
            tx_drop_out <= 1'b0;
        end else begin
            new_tx_out  <= launch;
            tx_drop_out <= bus_wr_in & ~thr_accept;
            if (launch) spi_dr_out <= thr;
            if (thr_accept)  thr_valid <= 1'b1;
            else if (launch) thr_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (thr_accept && !flush) thr <= bus_wdata_in;
    end

    spi_rx_fifo #(
        .DATA_W   (DATA_W),
        .RX_DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk_in),
        .flush     (flush),
        .push      (capture),
        .push_data (shift_in),
        .pop       (bus_rd_in),
        .head      (dr_rdata_out),
        .count     (rx_count_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_overflow)
    );

    always_ff @(posedge clk_in) begin
        if (flush)                          ovr_out <= 1'b0;
        else if (fifo_overflow & fifo_full) ovr_out <= 1'b1;
        else if (ovr_clr_in)                ovr_out <= 1'b0;
    end

    assign sptef_out = ~thr_valid;
    assign spif_out  = ~fifo_empty;
    assign busy_out  = (state == ST_BUSY);
    assign irq_out   = (spie_in & (spif_out | ovr_out)) | (sptie_in & sptef_out & spe_in);

endmodule

// File: doc/spi_data_buffer.md
Name: spi_data_buffer

Overview:
Data-path front end placed directly upstream of spi_core. Holds one transmit byte written by the register bus and launches it into spi_core with a one-cycle new_tx pulse. Captures each received byte from spi_core into a small RX FIFO when the core reports completion. Produces the SPTEF, SPIF and overrun status flags and the SPI interrupt request.

Parameters:
DATA_W, 8, width of the data register, TX holding register and RX entries
RX_DEPTH, 4, RX FIFO entries; must be a power of 2 and at least 2

Ports:
clk_in  input  1  system clock; the only clock
rst_in  input  1  synchronous, active-high reset
spe_in  input  1  SPI enable, SPI_CR1.SPE
spie_in  input  1  receive/overrun interrupt enable
sptie_in  input  1  transmit-empty interrupt enable
bus_wr_in  input  1  single-cycle write strobe to the data register
bus_wdata_in  input  DATA_W  write data
bus_rd_in  input  1  single-cycle read strobe of the data register; pops RX
ovr_clr_in  input  1  clears the sticky overrun flag
dr_rdata_out  output  DATA_W  RX FIFO head; 0 when the FIFO is empty
new_tx_out  output  1  one-cycle launch pulse to spi_core.new_tx_in
spi_dr_out  output  DATA_W  byte being transmitted, drives spi_core.spi_dr_in
finished_in  input  1  spi_core.finished_out, a level signal
shift_in  input  DATA_W  spi_core.shift_out, the received byte
sptef_out  output  1  TX holding register empty
spif_out  output  1  RX FIFO not empty
ovr_out  output  1  sticky overrun flag
rx_count_out  output  $clog2(RX_DEPTH)+1  RX FIFO occupancy
tx_drop_out  output  1  one-cycle pulse when a write is discarded
busy_out  output  1  a transfer is in flight
irq_out  output  1  interrupt request

Behaviour:
- Reset, taken on the clk_in edge while rst_in=1:
  - FSM goes to IDLE; thr_valid=0; FIFO is emptied; ovr=0.
  - Outputs: new_tx_out=0, spi_dr_out=0, tx_drop_out=0, sptef_out=1, spif_out=0, busy_out=0, rx_count_out=0, dr_rdata_out=0.
  - The finished_in edge register is cleared to 0.
  - Reset mid-transfer aborts the transfer; any completion that follows is not captured.
- TX holding register (thr):
  - bus_wr_in with thr_valid=0: thr<=bus_wdata_in, thr_valid<=1.
  - bus_wr_in with thr_valid=1: thr is unchanged and tx_drop_out pulses on the next cycle.
  - sptef_out = !thr_valid.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY when spe_in=1 and thr_valid=1. In that cycle: spi_dr_out<=thr, thr_valid<=0, new_tx_out<=1 for exactly one cycle.
  - Latency: a write at edge N launches at edge N+1, so new_tx_out is high during cycle N+1..N+2.
  - BUSY -> IDLE on the rising edge of finished_in, detected as finished_in & !finished_q with finished_q a registered copy. In that cycle shift_in is pushed into the RX FIFO.
  - A rising edge of finished_in while in IDLE is ignored.
  - Back-to-back transfers: a write accepted during BUSY launches on the first cycle in IDLE. The minimum gap from capture to the next new_tx_out is 1 cycle.
  - A write and a launch in the same cycle are both handled: thr moves to spi_dr_out and the new data is stored in thr.
  - spi_dr_out holds its value until the next launch.
- RX FIFO:
  - First-word-fall-through; dr_rdata_out shows the head.
  - bus_rd_in when not empty pops one entry. bus_rd_in when empty has no effect.
  - A push when full drops the new byte, keeps the existing contents and sets ovr=1.
  - Push and pop in the same cycle when full: the pop happens first, the push succeeds, no overrun, count unchanged.
  - Push and pop in the same cycle when empty: the push succeeds and the pop is ignored.
  - Pointers are $clog2(RX_DEPTH) bits wide and wrap naturally.
  - spif_out = (count != 0).
- Overrun: ovr is sticky. It is cleared by ovr_clr_in unless an overrun occurs in the same cycle, in which case set wins.
- spe_in=0 acts as a synchronous soft flush, equivalent to reset for all state except the finished_q register. The FSM returns to IDLE, new_tx_out=0, and a pending write is accepted into thr only once spe_in=1.
- irq_out = (spie_in & (spif_out | ovr_out)) | (sptie_in & sptef_out & spe_in). It is combinational from registered state only.
- busy_out = (state == BUSY).

Decomposition:
- spi_pkg holds the shared definitions:
  - DATA_W default
  - FSM state encodings ST_IDLE and ST_BUSY
  - CR1 bit-index constants shared with spi_core
- One sub-module, spi_rx_fifo, parameterised by DATA_W and RX_DEPTH.
  - Ports: push, push_data, pop, head, count, full, empty, overflow pulse.
  - Flush input driven by rst_in | !spe_in.

Test Plan:
1. Reset, then write 0xA5 at cycle 10. Required: new_tx_out high only during cycle 11, spi_dr_out=0xA5, sptef_out 1->0->1, busy_out=1. Then finished_in rises with shift_in=0x3C. Required: spif_out=1, dr_rdata_out=0x3C, rx_count_out=1.
2. Write 0x11 and write 0x22 during BUSY, then write 0x33 while thr is full. Required: tx_drop_out pulses once, the second launch carries 0x22, and 0x33 is never sent.
3. Complete 5 transfers with RX bytes 0x01..0x05 and no reads. Required: count=4, ovr_out=1, reads return 0x01..0x04, then dr_rdata_out=0. Pulse ovr_clr_in. Required: ovr_out=0.
4. FIFO full, finished_in edge and bus_rd_in in the same cycle. Required: ovr_out stays 0, count stays 4, the new byte lands at the tail.
5. Drop spe_in mid-transfer with 2 RX entries and thr full. Required: next cycle count=0, sptef_out=1, busy_out=0. A later finished_in edge captures nothing.
6. spie_in=1, sptie_in=0 with the FIFO empty. Required: irq_out=0; after one capture, irq_out=1; after the read, irq_out=0.
